// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: MDU opcode/state encodings and latency-class helpers (MDU_MADD_EN enables MADD-class decode)
package mdu_ctrl_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8,
      OP_MADD  = 4'd9,
      OP_MADDU = 4'd10,
      OP_MSUB  = 4'd11,
      OP_MSUBU = 4'd12
   } mdu_op_e;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   // Operations that occupy the multiplier for MULT_CYCLES
   function automatic logic is_mul(mdu_op_e op);
`ifdef MDU_MADD_EN
      return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
      return op inside {OP_MULT, OP_MULTU};
`endif
   endfunction

   // Operations that occupy the divider for DIV_CYCLES
   function automatic logic is_div(mdu_op_e op);
      return op inside {OP_DIV, OP_DIVU};
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 64-bit {HI,LO} result generator for mult/div (MADD-class under MDU_MADD_EN)
module mdu_arith
   import mdu_ctrl_pkg::*;
(
   input  mdu_op_e     i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
   output logic [63:0] o_res,
   output logic        o_wr
);

   logic [63:0] w_sa, w_sb, w_ps, w_pu, w_acc, w_mac;
   logic [31:0] w_dv, w_qs, w_rs, w_qu, w_ru;
   logic        w_dz;

   // Sign-extended 64-bit product keeps the signed result exact modulo 2^64
   assign w_sa  = {{32{i_a[31]}}, i_a};
   assign w_sb  = {{32{i_b[31]}}, i_b};
   assign w_ps  = w_sa * w_sb;
   assign w_pu  = {32'd0, i_a} * {32'd0, i_b};
   assign w_acc = {i_hi, i_lo};

   // Divisor forced to 1 on zero so the divider never sees /0; the write is suppressed instead
   assign w_dz  = (i_b == 32'd0);
   assign w_dv  = w_dz ? 32'd1 : i_b;
   assign w_qs  = $signed(i_a) / $signed(w_dv);
   assign w_rs  = $signed(i_a) % $signed(w_dv);
   assign w_qu  = i_a / w_dv;
   assign w_ru  = i_a % w_dv;

`ifdef MDU_MADD_EN
   assign w_mac = (i_op == OP_MADD)  ? w_acc + w_ps :
                  (i_op == OP_MADDU) ? w_acc + w_pu :
                  (i_op == OP_MSUB)  ? w_acc - w_ps :
                  (i_op == OP_MSUBU) ? w_acc - w_pu : w_acc;
`else
   assign w_mac = w_acc;
`endif

   // Result select; divide ops put remainder in HI and quotient in LO
   always_comb begin
      o_res = (i_op == OP_MULT)  ? w_ps :
              (i_op == OP_MULTU) ? w_pu :
              (i_op == OP_DIV)   ? {w_rs, w_qs} :
              (i_op == OP_DIVU)  ? {w_ru, w_qu} : w_mac;
      o_wr  = !(is_div(i_op) && w_dz);
   end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MDU sequencer owning HI/LO with stall generation (MDU_MADD_EN enables MADD-class ops)
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MDUOp,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        cancel,
   input  logic        D_use_mdu,
   output logic        busy,
   output logic        stall_mdu,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] HILO_out
);

   localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

   mdu_op_e       w_op;
   state_e        r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic          r_pend_wr, r_busy;
   logic [63:0]   w_res;
   logic          w_wr, w_go;

   assign w_op = mdu_op_e'(MDUOp);
   assign w_go = start & ~cancel & (is_mul(w_op) | is_div(w_op));

   mdu_arith u_arith (
      .i_op  (w_op),
      .i_a   (A),
      .i_b   (B),
      .i_hi  (r_hi),
      .i_lo  (r_lo),
      .o_res (w_res),
      .o_wr  (w_wr)
   );

   // Sequencer: capture result at start, count down the fixed latency, commit to HI/LO
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_pend_wr <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (w_go) begin
            r_state   <= S_RUN;
            r_cnt     <= is_div(w_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            r_busy    <= 1'b1;
            r_pend_hi <= w_res[63:32];
            r_pend_lo <= w_res[31:0];
            r_pend_wr <= w_wr;
         end else if (!cancel && w_op == OP_MTHI) begin
            r_hi <= A;
         end else if (!cancel && w_op == OP_MTLO) begin
            r_lo <= A;
         end
      end else if (r_cnt == CW'(1)) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         if (r_pend_wr) begin
            r_hi <= r_pend_hi;
            r_lo <= r_pend_lo;
         end
      end else begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign busy      = r_busy;
   assign stall_mdu = D_use_mdu & (start | r_busy);
   assign HI        = r_hi;
   assign LO        = r_lo;
   assign HILO_out  = (w_op == OP_MFHI) ? r_hi : (w_op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table-driven and randomized self-checking bench for mdu_ctrl (MDU_MADD_EN selects MADD-class expectations)
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  MDUOp = 4'd0;
   logic        start = 1'b0;
   logic [31:0] A = '0, B = '0;
   logic        cancel = 1'b0;
   logic        D_use_mdu = 1'b0;
   logic        busy, stall_mdu;
   logic [31:0] HI, LO, HILO_out;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .MDUOp(MDUOp), .start(start), .A(A), .B(B),
      .cancel(cancel), .D_use_mdu(D_use_mdu), .busy(busy), .stall_mdu(stall_mdu),
      .HI(HI), .LO(LO), .HILO_out(HILO_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic int lat(logic [3:0] op);
      if (op == OP_MULT || op == OP_MULTU) return 5;
      if (op == OP_DIV || op == OP_DIVU) return 10;
`ifdef MDU_MADD_EN
      if (op >= OP_MADD && op <= OP_MSUBU) return 5;
`endif
      return 0;
   endfunction

   // Architectural result of an MDU op from plain integer arithmetic
   function automatic logic [63:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [63:0] hl);
      longint sa, sb;
      logic [63:0] ua, ub;
      logic [31:0] q, r;
      sa = longint'(int'(a));
      sb = longint'(int'(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_MULT:  return sa * sb;
         OP_MULTU: return ua * ub;
         OP_DIV: begin
            if (b == 0) return hl;
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
            return {r, q};
         end
         OP_DIVU: begin
            if (b == 0) return hl;
            return {a % b, a / b};
         end
`ifdef MDU_MADD_EN
         OP_MADD:  return hl + sa * sb;
         OP_MADDU: return hl + ua * ub;
         OP_MSUB:  return hl - sa * sb;
         OP_MSUBU: return hl - ua * ub;
`endif
         default:  return hl;
      endcase
   endfunction

   task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
      MDUOp = op; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; MDUOp = OP_NONE;
      cyc = 0;
      while (busy && cyc < 40) begin
         cyc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic c);
      MDUOp = op; A = a; cancel = c;
      @(posedge clk); #1;
      MDUOp = OP_NONE; cancel = 1'b0;
   endtask

   initial begin
      int cyc;
      logic [3:0] op;
      logic [31:0] a, b;
      logic [63:0] e;

      tbl[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      tbl[1] = '{OP_MULTU, 32'hFFFFFFFE, 32'h3,        5,  32'h00000002, 32'hFFFFFFFA};
      tbl[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[3] = '{OP_DIVU,  32'h7,        32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      tbl[4] = '{OP_DIVU,  32'd100,      32'd7,        10, 32'h2,        32'hE};
      tbl[5] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
      tbl[6] = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 10, 32'h1,        32'hFFFFFFFD};
      tbl[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h0};
      tbl[8] = '{OP_DIV,   32'h80000000, 32'h2,        10, 32'h0,        32'hC0000000};
      tbl[9] = '{OP_DIV,   32'h5,        32'h0,        10, 32'h0,        32'hC0000000};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_hi", 64'(HI), 64'd0);
      chk("reset_lo", 64'(LO), 64'd0);
      chk("reset_stall", 64'(stall_mdu), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Table of directed vectors
      for (int i = 0; i < 10; i++) begin
         run(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
         chk($sformatf("tbl%0d_cycles", i), 64'(cyc), 64'(tbl[i].cyc));
         chk($sformatf("tbl%0d_hi", i), 64'(HI), 64'(tbl[i].hi));
         chk($sformatf("tbl%0d_lo", i), 64'(LO), 64'(tbl[i].lo));
         m_hi = tbl[i].hi; m_lo = tbl[i].lo;
      end

      // Stall window across a MULT with a dependent D-stage instruction
      D_use_mdu = 1'b1; MDUOp = OP_MULT; A = 32'd3; B = 32'd5; start = 1'b1;
      #1;
      chk("stall_start_cycle", 64'(stall_mdu), 64'd1);
      @(posedge clk); #1;
      start = 1'b0; MDUOp = OP_NONE;
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("stall_busy%0d", i), 64'(stall_mdu), 64'd1);
         @(posedge clk); #1;
      end
      chk("stall_released", 64'(stall_mdu), 64'd0);
      chk("stall_busy_low", 64'(busy), 64'd0);
      D_use_mdu = 1'b0; MDUOp = OP_MFLO; #1;
      chk("mflo_out", 64'(HILO_out), 64'd15);
      MDUOp = OP_MFHI; #1;
      chk("mfhi_out", 64'(HILO_out), 64'd0);
      MDUOp = OP_NONE; #1;
      chk("none_out", 64'(HILO_out), 64'd0);
      m_hi = 32'd0; m_lo = 32'd15;

      // MTHI cancelled, then taken
      mt(OP_MTHI, 32'h12345678, 1'b1);
      chk("mthi_cancel_hi", 64'(HI), 64'(m_hi));
      mt(OP_MTHI, 32'h12345678, 1'b0);
      chk("mthi_hi", 64'(HI), 64'h12345678);
      chk("mthi_busy", 64'(busy), 64'd0);
      m_hi = 32'h12345678;

      // Start cancelled: nothing launches
      MDUOp = OP_MULT; A = 32'd9; B = 32'd9; start = 1'b1; cancel = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0; MDUOp = OP_NONE;
      chk("cancel_start_busy", 64'(busy), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      chk("cancel_start_lo", 64'(LO), 64'(m_lo));

      // Cancel during RUN has no effect on the in-flight op
      MDUOp = OP_MULTU; A = 32'd6; B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; MDUOp = OP_NONE; cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("cancel_run_lo", 64'(LO), 64'd42);
      chk("cancel_run_hi", 64'(HI), 64'd0);
      m_hi = 32'd0; m_lo = 32'd42;

      // Reset in busy cycle 3 of a DIV
      MDUOp = OP_DIV; A = 32'd100; B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; MDUOp = OP_NONE;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mid_busy_before", 64'(busy), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_hi", 64'(HI), 64'd0);
      chk("rst_mid_lo", 64'(LO), 64'd0);
      repeat (12) @(posedge clk);
      #1;
      chk("rst_mid_no_commit", {HI, LO}, 64'd0);
      m_hi = 32'd0; m_lo = 32'd0;

      // MADDU across the LO carry
      mt(OP_MTHI, 32'd0, 1'b0);
      mt(OP_MTLO, 32'hFFFFFFFF, 1'b0);
      run(OP_MADDU, 32'd1, 32'd1, cyc);
`ifdef MDU_MADD_EN
      chk("maddu_cycles", 64'(cyc), 64'd5);
      chk("maddu_hilo", {HI, LO}, 64'h00000001_00000000);
      m_hi = 32'd1; m_lo = 32'd0;
`else
      chk("maddu_cycles", 64'(cyc), 64'd0);
      chk("maddu_hilo", {HI, LO}, 64'h00000000_FFFFFFFF);
      m_hi = 32'd0; m_lo = 32'hFFFFFFFF;
`endif

      // Randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 6))
            0: op = OP_MULT;
            1: op = OP_MULTU;
            2: op = OP_DIV;
            3: op = OP_DIVU;
            4: op = OP_MTHI;
            5: op = OP_MTLO;
            default: op = 4'(OP_MADD + $urandom_range(0, 3));
         endcase
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
         if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         if (op == OP_MTHI || op == OP_MTLO) begin
            mt(op, a, 1'b0);
            if (op == OP_MTHI) m_hi = a; else m_lo = a;
            chk($sformatf("rnd%0d_mt_busy", i), 64'(busy), 64'd0);
         end else begin
            e = model(op, a, b, {m_hi, m_lo});
            run(op, a, b, cyc);
            chk($sformatf("rnd%0d_op%0d_cycles", i, op), 64'(cyc), 64'(lat(op)));
            {m_hi, m_lo} = e;
         end
         chk($sformatf("rnd%0d_op%0d_hilo", i, op), {HI, LO}, {m_hi, m_lo});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer with HI/LO ownership; sits in the E stage beside the ALU.
- Consumes the decoded MDUOp/start from the control unit plus forwarded operands A/B.
- Models fixed mult/div latency with a countdown counter and commits results to HI/LO.
- Generates the MDU stall request for the hazard unit and drives mfhi/mflo read data toward the M-stage forward mux.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-class when enabled)
DIV_CYCLES, 10, busy cycles for DIV/DIVU

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
MDUOp  in  4  E-stage operation code (package encoding)
start  in  1  E-stage MDU instruction is mult/multu/div/divu (or MADD-class)
A  in  32  forwarded rs value
B  in  32  forwarded rt value
cancel  in  1  E-stage instruction is being killed this cycle (exception/flush)
D_use_mdu  in  1  D-stage instruction is md/mt/mf class
busy  out  1  operation in flight
stall_mdu  out  1  stall request to hazard unit
HI  out  32  architectural HI
LO  out  32  architectural LO
HILO_out  out  32  mfhi->HI, mflo->LO, else 0 (combinational on MDUOp)

Behaviour:
- Reset (reset==0 at posedge): HI=0, LO=0, busy=0, counter=0, pending results=0; stall_mdu then follows its equation and is 0 until D_use_mdu & start.
- States: IDLE, RUN. IDLE->RUN on start & ~cancel; counter loaded with MULT_CYCLES or DIV_CYCLES; operands' result computed at start and held in pend_hi/pend_lo.
- RUN: counter decrements every cycle; busy=1 while counter!=0. When counter reaches 1, next edge writes HI<=pend_hi, LO<=pend_lo, busy->0, return IDLE. Total: start in cycle t -> busy high t+1..t+N; HI/LO updated at end of cycle t+N.
- MULT: {HI,LO}=signed A*B (64b). MULTU: unsigned. DIV: LO=signed A/B, HI=signed A%B (remainder takes dividend sign). DIVU: unsigned.
- Divide by zero: operation still runs DIV_CYCLES, HI/LO remain unchanged at commit.
- MTHI/MTLO: HI or LO <= A at end of the E cycle, single cycle, no busy; suppressed when cancel=1.
- mfhi/mflo: HILO_out reads current HI/LO registers (no bypass of pending results; stall guarantees ordering).
- stall_mdu = D_use_mdu & (start | busy).
- start while busy: ignored (stall rules make it unreachable); in-flight op unaffected.
- cancel with start: op not started; cancel during RUN: no effect, in-flight op commits.
- Reset mid-operation: aborts, HI/LO cleared, busy=0 next cycle.

Optional Feature:
- MDU_MADD_EN defined: MADD/MADDU/MSUB/MSUBU decoded; {HI,LO} at commit = {HI,LO} value at start ± A*B (signed/unsigned 64b, wraps mod 2^64), latency MULT_CYCLES.
- Undefined: those codes treated as no-op (no start, no write, busy stays 0).

Decomposition:
- Shared package/macro file: MDUOp encoding NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12; state encoding IDLE/RUN.
- One sub-module natural: mdu_arith (pure combinational 64-bit result generator from op, A, B, HI, LO); mdu_ctrl keeps counter, FSM, HI/LO, stall.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3, start -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7, B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> HI/LO unchanged after 10 cycles.
- MULT started, D_use_mdu=1 (mflo) each cycle -> stall_mdu=1 from start cycle through last busy cycle, 0 the cycle after; then MDUOp=MFLO gives new LO on HILO_out.
- MTHI A=0x12345678 with cancel=1 -> HI unchanged; repeat cancel=0 -> HI=0x12345678 next cycle, busy stays 0.
- Reset (reset=0) asserted at busy cycle 3 of a DIV -> next cycle busy=0, HI=LO=0, no later commit.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 -> HI=1, LO=0 after 5 cycles; without macro same op -> no busy, HI/LO unchanged.
